// File: rtl/multicycle_sequencer_pkg.sv
// multicycle_sequencer_pkg: shared core package with the sequencer state
// encoding and the RV32I major-opcode constants used for decode.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_e;

    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    function automatic logic is_legal(input logic [4:0] op, input logic [1:0] lo);
        return lo == 2'b11 && (op inside {OP_REG, OP_IMM, OP_JALR, OP_LOAD, OP_STORE,
                                          OP_JAL, OP_BRANCH, OP_LUI, OP_AUIPC});
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return op == OP_LOAD || op == OP_STORE;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_control_logic.sv
// control_logic: FETCH/DECODE/EXECUTE/MEM/WB/TRAP sequencer with outputs
// decoded combinationally from the registered state and current inputs.
module control_logic
    import multicycle_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic [1:0] op_lo,
    input  logic       RegWEn_in,
    input  logic       MemRW_in,
    input  logic       halt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel,
    output logic       ir_en,
    output logic       pc_en,
    output logic       reg_we,
    output logic       trap,
    output logic       retire,
    output logic [2:0] state_o
);

    state_e state_q, state_d;
    logic   fetch_busy_q, fetch_busy_d;
    logic   fetch_req;

    // A fetch already on the bus stays requested even if halt rises mid-wait.
    always_comb begin
        fetch_req    = state_q == S_FETCH && (!halt || fetch_busy_q);
        fetch_busy_d = fetch_req && !mem_ready;
        state_d      = state_q;
        unique case (state_q)
            S_FETCH:   state_d = (fetch_req && mem_ready) ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = is_legal(opcode, op_lo) ? S_EXECUTE : S_TRAP;
            S_EXECUTE: state_d = is_mem(opcode) ? S_MEM : S_WB;
            S_MEM:     state_d = mem_ready ? S_WB : S_MEM;
            S_WB:      state_d = S_FETCH;
            default:   state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            fetch_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_busy_q <= fetch_busy_d;
        end
    end

    assign mem_req = rst_n && (fetch_req || state_q == S_MEM);
    assign mem_sel = rst_n && state_q == S_MEM;
    assign mem_we  = mem_sel && MemRW_in;
    assign ir_en   = rst_n && fetch_req && mem_ready;
    assign pc_en   = rst_n && state_q == S_WB;
    assign reg_we  = pc_en && RegWEn_in;
    assign retire  = pc_en;
    assign trap    = state_q == S_TRAP;
    assign state_o = state_q;

endmodule

// File: rtl/multicycle_sequencer_retire_counter.sv
// retire_counter: 32-bit retired-instruction counter, wraps modulo 2^32.
module retire_counter #(
    parameter logic [31:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q, count_d;

    assign count_d = inc ? count_q + 32'd1 : count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= RST_VAL;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle core control sequencer; couples the
// state machine with the retired-instruction counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter logic [31:0] INSTRET_RST = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  opcode,
    input  logic [1:0]  op_lo,
    input  logic        RegWEn_in,
    input  logic        MemRW_in,
    input  logic        halt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_en,
    output logic        pc_en,
    output logic        reg_we,
    output logic        trap,
    output logic [31:0] instret,
    output logic [2:0]  state_o
);

    logic retire;

    control_logic u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .op_lo     (op_lo),
        .RegWEn_in (RegWEn_in),
        .MemRW_in  (MemRW_in),
        .halt      (halt),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .ir_en     (ir_en),
        .pc_en     (pc_en),
        .reg_we    (reg_we),
        .trap      (trap),
        .retire    (retire),
        .state_o   (state_o)
    );

    retire_counter #(.RST_VAL(INSTRET_RST)) u_rc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (instret)
    );

endmodule
